alu_multicycle: RTL and testbench

Parametrised, registered successor to the 4-bit combinational ALU. Supports AND/OR/ADD/SUB plus XOR, signed set-less-than, logical shift-left and an iterative shift-add multiply. It sits between the operand source and the writeback stage. Both sides use a valid/ready handshake, and results and NZCV flags are held in output registers.

---
 rtl/alu_multicycle.sv | 145 ++++++++++++++
 tb/tb_alu_multicycle.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
`default_nettype none
// ============================================================================
// alu_multicycle : registered valid/ready ALU, single-cycle ops + shift-add MUL
// Revision      : 1.0
// ============================================================================
module alu_multicycle #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [2:0]       ALUcontrol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUresult,
  output logic [3:0]       ALUflags
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_BUSY = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  localparam logic [CW-1:0] c_ITERS = CW'(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             w_is_sub;
  logic             w_arith;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH:0]   w_sum;
  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // Single-cycle datapath works on the live inputs; it is only used at accept.
  always_comb begin
    w_is_sub = (ALUcontrol == 3'b011);
    w_arith  = (ALUcontrol == 3'b010) || w_is_sub;
    w_b_eff  = w_is_sub ? ~SrcB : SrcB;
    w_sum    = {1'b0, SrcA} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, w_is_sub};
    w_shamt  = SrcB[SHW-1:0];
    case (ALUcontrol)
      3'b000:  w_res = SrcA & SrcB;
      3'b001:  w_res = SrcA | SrcB;
      3'b010:  w_res = w_sum[WIDTH-1:0];
      3'b011:  w_res = w_sum[WIDTH-1:0];
      3'b100:  w_res = SrcA ^ SrcB;
      3'b101:  w_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      3'b111:  w_res = SrcA << w_shamt;
      default: w_res = '0;
    endcase
    w_c = w_arith & w_sum[WIDTH];
    // Overflow: effective operands share a sign that the result does not.
    w_v = w_arith & ~(SrcA[WIDTH-1] ^ w_b_eff[WIDTH-1]) & (SrcA[WIDTH-1] ^ w_res[WIDTH-1]);
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    result_d = result_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    case (state_q)
      c_IDLE: begin
        if (in_valid) begin
          if (ALUcontrol == 3'b110) begin
            state_d  = c_BUSY;
            mcand_d  = SrcA;
            mplier_d = SrcB;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            state_d  = c_DONE;
            result_d = w_res;
            flags_d  = {w_res[WIDTH-1], (w_res == '0), w_c, w_v};
          end
        end
      end
      c_BUSY: begin
        if (cnt_q == c_ITERS) begin
          state_d  = c_DONE;
          result_d = acc_q;
          flags_d  = {acc_q[WIDTH-1], (acc_q == '0), 2'b00};
        end else begin
          // Shifting both operands is equivalent to testing bit[cnt] of B
          // and adding A<<cnt, without a variable index.
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
        end
      end
      c_DONE: begin
        if (out_ready) begin
          state_d = c_IDLE;
        end
      end
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      result_q <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == c_IDLE);
  assign out_valid = (state_q == c_DONE);
  assign ALUresult = result_q;
  assign ALUflags  = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_multicycle.sv
`default_nettype none
// ============================================================================
// tb_alu_multicycle : checks 4- and 32-bit instances against an arithmetic model
// Revision          : 1.0
// ============================================================================
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst4, rst32;
  logic        iv4, ir4, ov4, or4;
  logic [3:0]  a4, b4, res4, fl4;
  logic [2:0]  op4;
  logic        iv32, ir32, ov32, or32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  fl32;
  logic [2:0]  op32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_multicycle #(.WIDTH(4)) u_alu4 (
    .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4),
    .SrcA(a4), .SrcB(b4), .ALUcontrol(op4),
    .out_valid(ov4), .out_ready(or4), .ALUresult(res4), .ALUflags(fl4)
  );

  alu_multicycle #(.WIDTH(32)) u_alu32 (
    .clk(clk), .reset(rst32), .in_valid(iv32), .in_ready(ir32),
    .SrcA(a32), .SrcB(b32), .ALUcontrol(op32),
    .out_valid(ov32), .out_ready(or32), .ALUresult(res32), .ALUflags(fl32)
  );

  // Reference: {N,Z,C,V, result[31:0]} from integer arithmetic on w-bit values.
  function automatic logic [35:0] model(int w, logic [31:0] ai, logic [31:0] bi, logic [2:0] op);
    longint unsigned m, a, b, r;
    longint sa, sb, half, s;
    bit c, v, n, z;
    m    = (64'd1 << w) - 64'd1;
    a    = ai & m;
    b    = bi & m;
    half = longint'(64'd1 << (w - 1));
    sa   = (longint'(a) >= half) ? longint'(a) - 2 * half : longint'(a);
    sb   = (longint'(b) >= half) ? longint'(b) - 2 * half : longint'(b);
    c = 0; v = 0; r = 0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: begin
        r = (a + b) & m; c = (a + b) > m; s = sa + sb; v = (s >= half) || (s < -half);
      end
      3'd3: begin
        r = (a - b) & m; c = (a >= b); s = sa - sb; v = (s >= half) || (s < -half);
      end
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 1 : 0;
      3'd6: r = (a * b) & m;
      default: r = (a << (b % longint'(w))) & m;
    endcase
    n = ((r >> (w - 1)) & 1) != 0;
    z = (r == 0);
    model = {n, z, c, v, r[31:0]};
  endfunction

  // Issue one op, wait for out_valid, then let out_ready=1 complete the handshake.
  task automatic drive(input bit w32, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op, output logic [31:0] res,
                       output logic [3:0] fl, output int edges, output bit ir_ok);
    @(negedge clk);
    if (w32) begin iv32 = 1; a32 = a; b32 = b; op32 = op; end
    else     begin iv4 = 1; a4 = a[3:0]; b4 = b[3:0]; op4 = op; end
    @(posedge clk); #1;
    if (w32) begin iv32 = 0; a32 = $urandom; b32 = $urandom; op32 = 3'($urandom); end
    else     begin iv4 = 0; a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom); end
    edges = 0;
    ir_ok = 1;
    while (!(w32 ? ov32 : ov4) && edges < 200) begin
      if (w32 ? ir32 : ir4) ir_ok = 0;
      @(posedge clk); #1;
      edges++;
    end
    if (w32 ? ir32 : ir4) ir_ok = 0;
    res = w32 ? res32 : {28'b0, res4};
    fl  = w32 ? fl32 : fl4;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst4 = 1; rst32 = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ov4 !== 1'b0)   begin failures++; $display("FAIL reset_ov4 got=%b exp=0", ov4); end
    checks++; if (ir4 !== 1'b1)   begin failures++; $display("FAIL reset_ir4 got=%b exp=1", ir4); end
    checks++; if ({fl4, res4} !== 8'h00) begin failures++; $display("FAIL reset_out4 got=%h exp=00", {fl4, res4}); end
    checks++; if (ov32 !== 1'b0)  begin failures++; $display("FAIL reset_ov32 got=%b exp=0", ov32); end
    checks++; if (ir32 !== 1'b1)  begin failures++; $display("FAIL reset_ir32 got=%b exp=1", ir32); end
    checks++; if ({fl32, res32} !== 36'h0) begin failures++; $display("FAIL reset_out32 got=%h exp=0", {fl32, res32}); end
    @(negedge clk); rst4 = 0; rst32 = 0;
  endtask

  task automatic test_directed4();
    logic [2:0] ops[8]  = '{3'd2, 3'd3, 3'd3, 3'd2, 3'd5, 3'd7, 3'd4, 3'd0};
    logic [3:0] as[8]   = '{4'b0111, 4'b1100, 4'b0110, 4'b1111, 4'b1100, 4'b0011, 4'b1010, 4'b1010};
    logic [3:0] bs[8]   = '{4'b0001, 4'b1111, 4'b0110, 4'b0001, 4'b0001, 4'b0110, 4'b0110, 4'b0000};
    logic [3:0] er[8]   = '{4'b1000, 4'b1101, 4'b0000, 4'b0000, 4'b0001, 4'b1100, 4'b1100, 4'b0000};
    logic [3:0] ef[8]   = '{4'b1001, 4'b1000, 4'b0110, 4'b0110, 4'b0000, 4'b1000, 4'b1000, 4'b0100};
    logic [31:0] r; logic [3:0] f; int e; bit ok;
    for (int i = 0; i < 8; i++) begin
      drive(0, {28'b0, as[i]}, {28'b0, bs[i]}, ops[i], r, f, e, ok);
      checks++; if (r[3:0] !== er[i]) begin failures++; $display("FAIL dir4_res[%0d] got=%b exp=%b", i, r[3:0], er[i]); end
      checks++; if (f !== ef[i])      begin failures++; $display("FAIL dir4_flags[%0d] got=%b exp=%b", i, f, ef[i]); end
      checks++; if (e !== 0 || !ok)   begin failures++; $display("FAIL dir4_lat[%0d] edges=%0d exp=0 ir_ok=%0d", i, e, ok); end
    end
  endtask

  task automatic test_mul32();
    logic [31:0] r; logic [3:0] f; int e; bit ok;
    drive(1, 32'h0001_0003, 32'h0000_0005, 3'd6, r, f, e, ok);
    checks++; if (r !== 32'h0005_000F) begin failures++; $display("FAIL mul32_res got=%h exp=0005000f", r); end
    checks++; if (f !== 4'b0000)       begin failures++; $display("FAIL mul32_flags got=%b exp=0000", f); end
    checks++; if (e !== 33)            begin failures++; $display("FAIL mul32_lat got=%0d exp=33", e); end
    checks++; if (!ok)                 begin failures++; $display("FAIL mul32_inready got=1 exp=0 while busy"); end
    drive(1, 32'hFFFF_FFFF, 32'h0000_0002, 3'd6, r, f, e, ok);
    checks++; if ({f, r} !== {4'b1000, 32'hFFFF_FFFE}) begin failures++; $display("FAIL mul32_neg got=%h exp=8fffffffe", {f, r}); end
  endtask

  task automatic test_random(input bit w32, input int n);
    logic [31:0] a, b, r; logic [3:0] f; logic [2:0] op; logic [35:0] exp;
    int e, w, elat; bit ok;
    w = w32 ? 32 : 4;
    for (int i = 0; i < n; i++) begin
      a = $urandom; b = $urandom; op = 3'($urandom);
      if (w32 && op == 3'd6 && ($urandom % 3) != 0) op = 3'd2;
      if (($urandom % 5) == 0) b = a;
      exp  = model(w, a, b, op);
      elat = (op == 3'd6) ? w + 1 : 0;
      drive(w32, a, b, op, r, f, e, ok);
      if (!w32) exp[31:4] = 28'b0;
      checks++;
      if ({f, r} !== exp || e !== elat || !ok) begin
        failures++;
        $display("FAIL rand%0d[%0d] op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d ir_ok=%0d",
                 w, i, op, a, b, {f, r}, e, exp, elat, ok);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b; logic [35:0] exp; int n;
    a = $urandom; b = $urandom;
    exp = model(32, a, b, 3'd2);
    or32 = 0;
    @(negedge clk); iv32 = 1; a32 = a; b32 = b; op32 = 3'd2;
    @(posedge clk); #1; iv32 = 0;
    n = 0;
    while (!ov32 && n < 10) begin @(posedge clk); #1; n++; end
    checks++; if (ov32 !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b exp=1", ov32); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); iv32 = ~iv32; a32 = $urandom; b32 = $urandom; op32 = 3'($urandom);
      @(posedge clk); #1;
      checks++;
      if (ov32 !== 1'b1 || ir32 !== 1'b0 || {fl32, res32} !== exp) begin
        failures++;
        $display("FAIL bp_hold[%0d] ov=%b ir=%b got=%h exp ov=1 ir=0 %h", i, ov32, ir32, {fl32, res32}, exp);
      end
    end
    @(negedge clk); iv32 = 0; or32 = 1;
    @(posedge clk); #1;
    checks++; if (ir32 !== 1'b1 || ov32 !== 1'b0) begin failures++; $display("FAIL bp_release ir=%b ov=%b exp ir=1 ov=0", ir32, ov32); end
    @(posedge clk); #1;
    checks++; if (ir32 !== 1'b1) begin failures++; $display("FAIL bp_idle ir=%b exp=1", ir32); end
  endtask

  task automatic test_reset_mid_mul();
    logic [31:0] r; logic [3:0] f; int e; bit ok, seen;
    drive(1, 32'h0000_0001, 32'h0000_0002, 3'd1, r, f, e, ok);
    checks++; if (r !== 32'h3) begin failures++; $display("FAIL rm_pre got=%h exp=3", r); end
    @(negedge clk); iv32 = 1; a32 = $urandom | 32'h1; b32 = $urandom | 32'h1; op32 = 3'd6;
    @(posedge clk); #1; iv32 = 0;
    repeat (9) @(posedge clk);
    @(negedge clk); rst32 = 1;
    @(posedge clk); #1;
    checks++;
    if (ov32 !== 1'b0 || ir32 !== 1'b1 || {fl32, res32} !== 36'h0) begin
      failures++;
      $display("FAIL rm_reset ov=%b ir=%b out=%h exp ov=0 ir=1 out=0", ov32, ir32, {fl32, res32});
    end
    @(negedge clk); rst32 = 0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (ov32) seen = 1; end
    checks++; if (seen) begin failures++; $display("FAIL rm_abandon out_valid=1 exp=0"); end
    drive(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 3'd0, r, f, e, ok);
    checks++; if ({f, r} !== {4'b1000, 32'hF000_F000}) begin failures++; $display("FAIL rm_and got=%h exp=8f000f000", {f, r}); end
  endtask

  initial begin
    iv4 = 0; or4 = 1; a4 = 0; b4 = 0; op4 = 0;
    iv32 = 0; or32 = 1; a32 = 0; b32 = 0; op32 = 0;
    test_reset();
    test_directed4();
    test_random(0, 60);
    test_mul32();
    test_random(1, 40);
    test_backpressure();
    test_reset_mid_mul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
